ul_cfg_loader: RTL and testbench

- Parametrised next-generation config loader for the ped/bhp operators.
- On an operator request it fetches a header word from the SoC config port and checks it against the requested address.
- On a match it streams a selectable number of channels' worth of words and assembles each channel's CFG_W-bit configuration LSB-first.
- Adds retry limiting, beat timeout, error reporting, partial channel loads and per-channel update strobes; channel registers hold between loads.

---
 rtl/ul_cfg_loader_if.sv | 30 +++
 rtl/ul_cfg_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_ul_cfg_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ul_cfg_loader_if.sv
// Operator request/response, SoC config port and channel outputs of ul_cfg_loader.
// The loader attaches through the slave modport; the operator/SoC side uses master.
interface ul_cfg_loader_if #(
    parameter int WORD_W = 32,
    parameter int CFG_W  = 256,
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 32
);
    logic                         soc_req;
    logic                         soc_valid;
    logic [WORD_W-1:0]            soc_data;
    logic                         ul_req;
    logic [ADDR_W-1:0]            ul_addr;
    logic [$clog2(NUM_CH+1)-1:0]  ul_ch_num;
    logic                         ul_busy;
    logic                         ul_valid;
    logic                         ul_err;
    logic [NUM_CH-1:0]            ch_update;
    logic [NUM_CH*CFG_W-1:0]      ch_data;

    modport master (
        output soc_valid, soc_data, ul_req, ul_addr, ul_ch_num,
        input  soc_req, ul_busy, ul_valid, ul_err, ch_update, ch_data
    );

    modport slave (
        input  soc_valid, soc_data, ul_req, ul_addr, ul_ch_num,
        output soc_req, ul_busy, ul_valid, ul_err, ch_update, ch_data
    );
endinterface

// File: rtl/ul_cfg_loader.sv
// Config loader: fetches and checks a header from the SoC port, then assembles
// CFG_W-bit channel words LSB-first into NUM_CH registered channel slots.
module ul_cfg_loader #(
    parameter int WORD_W    = 32,
    parameter int CFG_W     = 256,
    parameter int NUM_CH    = 8,
    parameter int ADDR_W    = 32,
    parameter int RETRY_MAX = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            syn_rst,
    ul_cfg_loader_if.slave  io_bus
);
    localparam int WPC   = CFG_W / WORD_W;
    localparam int CHN_W = $clog2(NUM_CH + 1);
    localparam int CI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WC_W  = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int RT_W  = $clog2(RETRY_MAX + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_HDR  = 3'd2,
        S_LOAD = 3'd3,
        S_FAIL = 3'd4,
        S_RESP = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic [ADDR_W-1:0]        r_addr;
    logic [CI_W-1:0]          r_ch_last;
    logic [RT_W-1:0]          r_retry_cnt;
    logic [TMO_W-1:0]         r_tmo_cnt;
    logic [WC_W-1:0]          r_word_cnt;
    logic [CI_W-1:0]          r_ch_idx;
    logic [CFG_W-1:0]         r_asm;
    logic [NUM_CH*CFG_W-1:0]  r_ch_data;
    logic [NUM_CH-1:0]        r_ch_update;
    logic                     r_soc_req;
    logic                     r_busy;
    logic                     r_valid;
    logic                     r_err;

    logic [CHN_W-1:0]         w_ch_eff;
    logic [CFG_W-1:0]         w_asm_next;
    logic                     w_accept;
    logic                     w_hdr_beat;
    logic                     w_hdr_match;
    logic                     w_beat;
    logic                     w_last_word;
    logic                     w_last_ch;
    logic                     w_tmo_hit;
    logic                     w_in_xfer;

    assign w_accept    = (r_state == S_IDLE) && io_bus.ul_req;
    assign w_hdr_beat  = (r_state == S_HDR) && io_bus.soc_valid;
    assign w_hdr_match = (io_bus.soc_data[ADDR_W-1:0] == r_addr);
    assign w_beat      = (r_state == S_LOAD) && io_bus.soc_valid;
    assign w_last_word = (r_word_cnt == WC_W'(WPC - 1));
    assign w_last_ch   = (r_ch_idx == r_ch_last);
    // The counter is one step short of TIMEOUT-1 here: the error fires on the cycle it would reach it.
    assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TIMEOUT - 2));
    assign w_in_xfer   = (r_state == S_HDR) || (r_state == S_LOAD);

    // Effective channel count: zero or out-of-range requests mean all channels.
    always_comb begin
        w_ch_eff = io_bus.ul_ch_num;
        if ((io_bus.ul_ch_num == CHN_W'(0)) || (io_bus.ul_ch_num > CHN_W'(NUM_CH))) begin
            w_ch_eff = CHN_W'(NUM_CH);
        end else begin
            w_ch_eff = io_bus.ul_ch_num;
        end
    end

    // Assembly value including the current beat, so the last beat lands in the channel directly.
    always_comb begin
        w_asm_next = r_asm;
        for (int i = 0; i < WPC; i++) begin
            w_asm_next[i*WORD_W +: WORD_W] = (r_word_cnt == WC_W'(i)) ?
                                             io_bus.soc_data : r_asm[i*WORD_W +: WORD_W];
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.ul_req) w_next = S_REQ;
                else               w_next = S_IDLE;
            end
            S_REQ:  w_next = S_HDR;
            S_HDR: begin
                if (io_bus.soc_valid) begin
                    if (w_hdr_match) w_next = S_LOAD;
                    else             w_next = S_FAIL;
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_HDR;
                end
            end
            S_FAIL: begin
                if (r_retry_cnt == RT_W'(RETRY_MAX)) w_next = S_ERR;
                else if (!io_bus.soc_valid)         w_next = S_REQ;
                else                                 w_next = S_FAIL;
            end
            S_LOAD: begin
                if (io_bus.soc_valid) begin
                    if (w_last_word && w_last_ch) w_next = S_RESP;
                    else                          w_next = S_LOAD;
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_RESP:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_state <= S_IDLE;
        else if (syn_rst) r_state <= S_IDLE;
        else              r_state <= w_next;
    end

    // Status outputs decoded from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_soc_req <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else if (syn_rst) begin
            r_soc_req <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_soc_req <= (w_next == S_REQ);
            r_busy    <= (w_next != S_IDLE);
            r_valid   <= (w_next == S_RESP);
            r_err     <= (w_next == S_ERR);
        end
    end

    // Request latch, retry/timeout counters and word assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= ADDR_W'(0);
            r_ch_last   <= CI_W'(0);
            r_retry_cnt <= RT_W'(0);
            r_tmo_cnt   <= TMO_W'(0);
            r_word_cnt  <= WC_W'(0);
            r_ch_idx    <= CI_W'(0);
            r_asm       <= CFG_W'(0);
        end else if (syn_rst) begin
            r_addr      <= ADDR_W'(0);
            r_ch_last   <= CI_W'(0);
            r_retry_cnt <= RT_W'(0);
            r_tmo_cnt   <= TMO_W'(0);
            r_word_cnt  <= WC_W'(0);
            r_ch_idx    <= CI_W'(0);
            r_asm       <= CFG_W'(0);
        end else begin
            if (w_accept) begin
                r_addr      <= io_bus.ul_addr;
                r_ch_last   <= CI_W'(w_ch_eff - CHN_W'(1));
                r_retry_cnt <= RT_W'(0);
            end
            if (w_hdr_beat) begin
                r_word_cnt <= WC_W'(0);
                r_ch_idx   <= CI_W'(0);
                if (!w_hdr_match) r_retry_cnt <= r_retry_cnt + RT_W'(1);
            end
            // Outside HDR/LOAD the counter is held at zero, which covers the clear on entry.
            if (io_bus.soc_valid || !w_in_xfer) r_tmo_cnt <= TMO_W'(0);
            else                                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (w_beat) begin
                r_asm <= w_asm_next;
                if (w_last_word) begin
                    r_word_cnt <= WC_W'(0);
                    r_ch_idx   <= r_ch_idx + CI_W'(1);
                end else begin
                    r_word_cnt <= r_word_cnt + WC_W'(1);
                end
            end
        end
    end

    // Channel registers and their one-cycle update strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_data   <= (NUM_CH*CFG_W)'(0);
            r_ch_update <= NUM_CH'(0);
        end else if (syn_rst) begin
            r_ch_data   <= (NUM_CH*CFG_W)'(0);
            r_ch_update <= NUM_CH'(0);
        end else begin
            r_ch_update <= NUM_CH'(0);
            if (w_beat && w_last_word) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_ch_idx == CI_W'(i)) begin
                        r_ch_data[i*CFG_W +: CFG_W] <= w_asm_next;
                        r_ch_update[i]              <= 1'b1;
                    end
                end
            end
        end
    end

    assign io_bus.soc_req   = r_soc_req;
    assign io_bus.ul_busy   = r_busy;
    assign io_bus.ul_valid  = r_valid;
    assign io_bus.ul_err    = r_err;
    assign io_bus.ch_update = r_ch_update;
    assign io_bus.ch_data   = r_ch_data;
endmodule

// File: tb/tb_ul_cfg_loader.sv
// Directed bench for ul_cfg_loader (8 channels x 256 bits, 32-bit words, short timeout).
module tb_ul_cfg_loader;
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic syn_rst = 1'b0;

    ul_cfg_loader_if #(.WORD_W(32), .CFG_W(256), .NUM_CH(8), .ADDR_W(32)) bus ();

    ul_cfg_loader #(
        .WORD_W(32), .CFG_W(256), .NUM_CH(8), .ADDR_W(32), .RETRY_MAX(3), .TIMEOUT(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .syn_rst(syn_rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    int         n_req   = 0;
    int         n_err   = 0;
    int         n_valid = 0;
    logic [7:0] upd_or  = 8'h00;

    // Advance one clock; outputs are read 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.soc_req)  n_req++;
        if (bus.ul_err)   n_err++;
        if (bus.ul_valid) n_valid++;
        upd_or = upd_or | bus.ch_update;
    endtask

    task automatic clear_mon();
        n_req = 0; n_err = 0; n_valid = 0; upd_or = 8'h00;
    endtask

    // Present ul_req for one cycle; returns in the REQ cycle.
    task automatic issue_req(input logic [31:0] addr, input logic [3:0] chn);
        bus.ul_req = 1'b1; bus.ul_addr = addr; bus.ul_ch_num = chn;
        step();
        bus.ul_req = 1'b0;
    endtask

    // From the REQ cycle: move to HDR, present one header beat, return in the following cycle.
    task automatic send_hdr(input logic [31:0] hdr);
        step();
        bus.soc_valid = 1'b1; bus.soc_data = hdr;
        step();
        bus.soc_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        bus.soc_valid = 1'b1; bus.soc_data = d;
        step();
        bus.soc_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [255:0] ch;
        bus.soc_valid = 1'b0; bus.soc_data = 32'h0; bus.ul_req = 1'b0;
        bus.ul_addr = 32'h0; bus.ul_ch_num = 4'd0;
        rst_n = 1'b0; syn_rst = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({bus.soc_req, bus.ul_busy, bus.ul_valid, bus.ul_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.soc_req, bus.ul_busy, bus.ul_valid, bus.ul_err});
        end
        n_cmp++;
        if (bus.ch_update !== 8'h00) begin
            n_bad++; $display("FAIL reset_update: got %h expected 00", bus.ch_update);
        end
        for (int c = 0; c < 8; c++) begin
            ch = bus.ch_data[c*256 +: 256];
            n_cmp++;
            if (ch !== 256'h0) begin
                n_bad++; $display("FAIL reset_ch%0d: got %h expected 0", c, ch);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (bus.ul_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_busy: got %b expected 0", bus.ul_busy);
        end
    endtask

    task automatic test_full_load();
        int         t0;
        int         vcyc;
        logic [7:0] exp_upd;
        logic [31:0] got;
        clear_mon();
        t0 = cyc; vcyc = -1;
        issue_req(32'h0000_1000, 4'd0);
        n_cmp++;
        if ({bus.soc_req, bus.ul_busy} !== 2'b11) begin
            n_bad++; $display("FAIL t1_req_busy: got %b expected 11", {bus.soc_req, bus.ul_busy});
        end
        send_hdr(32'h0000_1000);
        for (int k = 0; k < 64; k++) begin
            bus.ul_req  = (k == 10);
            bus.ul_addr = 32'h0000_2000;
            send_beat(32'(k));
            exp_upd = ((k % 8) == 7) ? (8'h01 << (k / 8)) : 8'h00;
            n_cmp++;
            if (bus.ch_update !== exp_upd) begin
                n_bad++; $display("FAIL t1_update beat %0d: got %h expected %h", k, bus.ch_update, exp_upd);
            end
            n_cmp++;
            if (bus.ul_valid !== ((k == 63) ? 1'b1 : 1'b0)) begin
                n_bad++; $display("FAIL t1_valid beat %0d: got %b", k, bus.ul_valid);
            end
            if (bus.ul_valid) vcyc = cyc - t0;
        end
        bus.ul_req = 1'b0;
        step();
        n_cmp++;
        if ({bus.ul_busy, bus.ul_valid} !== 2'b00) begin
            n_bad++; $display("FAIL t1_idle: got %b expected 00", {bus.ul_busy, bus.ul_valid});
        end
        n_cmp++;
        if (vcyc !== 67) begin
            n_bad++; $display("FAIL t1_latency: got %0d expected 67", vcyc);
        end
        n_cmp++;
        if ({n_req, n_valid, n_err} !== {32'd1, 32'd1, 32'd0}) begin
            n_bad++; $display("FAIL t1_pulses: got req=%0d valid=%0d err=%0d expected 1 1 0", n_req, n_valid, n_err);
        end
        for (int c = 0; c < 8; c++) begin
            for (int w = 0; w < 8; w++) begin
                got = bus.ch_data[c*256 + w*32 +: 32];
                n_cmp++;
                if (got !== 32'(c*8 + w)) begin
                    n_bad++; $display("FAIL t1_data ch%0d w%0d: got %h expected %h", c, w, got, 32'(c*8 + w));
                end
            end
        end
    endtask

    task automatic test_partial();
        logic [31:0] got;
        logic [31:0] exp;
        clear_mon();
        issue_req(32'h0000_1000, 4'd12);
        send_hdr(32'h0000_1000);
        for (int k = 0; k < 64; k++) send_beat(32'hA5A5_A5A5);
        step();
        n_cmp++;
        if ({n_valid, 24'h0, upd_or} !== {32'd1, 32'h0000_00FF}) begin
            n_bad++; $display("FAIL t2_preload: got valid=%0d upd=%h expected 1 ff", n_valid, upd_or);
        end
        clear_mon();
        issue_req(32'h0000_1000, 4'd2);
        send_hdr(32'h0000_1000);
        for (int k = 0; k < 16; k++) send_beat(32'(k));
        n_cmp++;
        if ({bus.ul_valid, bus.ch_update} !== {1'b1, 8'h02}) begin
            n_bad++; $display("FAIL t2_final: got valid=%b upd=%h expected 1 02", bus.ul_valid, bus.ch_update);
        end
        repeat (4) step();
        n_cmp++;
        if ({n_valid, 24'h0, upd_or} !== {32'd1, 32'h0000_0003}) begin
            n_bad++; $display("FAIL t2_strobes: got valid=%0d upd=%h expected 1 03", n_valid, upd_or);
        end
        for (int c = 0; c < 8; c++) begin
            for (int w = 0; w < 8; w++) begin
                got = bus.ch_data[c*256 + w*32 +: 32];
                exp = (c < 2) ? 32'(c*8 + w) : 32'hA5A5_A5A5;
                n_cmp++;
                if (got !== exp) begin
                    n_bad++; $display("FAIL t2_data ch%0d w%0d: got %h expected %h", c, w, got, exp);
                end
            end
        end
    endtask

    task automatic test_retry_exhaust();
        logic [31:0] got;
        clear_mon();
        issue_req(32'h0000_1000, 4'd0);
        for (int r = 0; r < 3; r++) begin
            step();
            bus.soc_valid = 1'b1; bus.soc_data = 32'h0000_2000;
            step();
            bus.soc_valid = 1'b0;
            step();
        end
        n_cmp++;
        if (bus.ul_err !== 1'b1) begin
            n_bad++; $display("FAIL t3_err_pulse: got %b expected 1", bus.ul_err);
        end
        step();
        n_cmp++;
        if ({bus.ul_busy, bus.ul_err} !== 2'b00) begin
            n_bad++; $display("FAIL t3_idle: got %b expected 00", {bus.ul_busy, bus.ul_err});
        end
        repeat (5) step();
        n_cmp++;
        if ({n_req, n_err, n_valid} !== {32'd3, 32'd1, 32'd0}) begin
            n_bad++; $display("FAIL t3_pulses: got req=%0d err=%0d valid=%0d expected 3 1 0", n_req, n_err, n_valid);
        end
        n_cmp++;
        if (upd_or !== 8'h00) begin
            n_bad++; $display("FAIL t3_no_update: got %h expected 00", upd_or);
        end
        got = bus.ch_data[256 + 7*32 +: 32];
        n_cmp++;
        if (got !== 32'd15) begin
            n_bad++; $display("FAIL t3_hold: got %h expected 0000000f", got);
        end
    endtask

    task automatic test_retry_recover();
        logic [31:0] got;
        clear_mon();
        issue_req(32'h0000_1000, 4'd1);
        send_hdr(32'h0000_2000);
        step();
        send_hdr(32'h0000_1000);
        for (int k = 0; k < 8; k++) send_beat(32'h100 + 32'(k));
        n_cmp++;
        if (bus.ul_valid !== 1'b1) begin
            n_bad++; $display("FAIL t4_valid: got %b expected 1", bus.ul_valid);
        end
        repeat (3) step();
        n_cmp++;
        if ({n_req, n_err, n_valid} !== {32'd2, 32'd0, 32'd1}) begin
            n_bad++; $display("FAIL t4_pulses: got req=%0d err=%0d valid=%0d expected 2 0 1", n_req, n_err, n_valid);
        end
        n_cmp++;
        if (upd_or !== 8'h01) begin
            n_bad++; $display("FAIL t4_update: got %h expected 01", upd_or);
        end
        for (int w = 0; w < 8; w++) begin
            got = bus.ch_data[w*32 +: 32];
            n_cmp++;
            if (got !== 32'h100 + 32'(w)) begin
                n_bad++; $display("FAIL t4_data w%0d: got %h expected %h", w, got, 32'h100 + 32'(w));
            end
        end
    endtask

    task automatic test_timeout();
        int          lat;
        logic [31:0] got;
        clear_mon();
        issue_req(32'h0000_1000, 4'd1);
        send_hdr(32'h0000_1000);
        for (int k = 0; k < 5; k++) send_beat(32'hDEAD_0000 + 32'(k));
        lat = 1;
        while (!bus.ul_err && lat < 40) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== 16) begin
            n_bad++; $display("FAIL t5_timeout_cycles: got %0d expected 16", lat);
        end
        step();
        n_cmp++;
        if ({bus.ul_busy, n_err, n_valid} !== {1'b0, 32'd1, 32'd0}) begin
            n_bad++; $display("FAIL t5_end: got busy=%b err=%0d valid=%0d expected 0 1 0", bus.ul_busy, n_err, n_valid);
        end
        n_cmp++;
        if (upd_or !== 8'h00) begin
            n_bad++; $display("FAIL t5_no_update: got %h expected 00", upd_or);
        end
        for (int w = 0; w < 8; w++) begin
            got = bus.ch_data[w*32 +: 32];
            n_cmp++;
            if (got !== 32'h100 + 32'(w)) begin
                n_bad++; $display("FAIL t5_ch0_hold w%0d: got %h expected %h", w, got, 32'h100 + 32'(w));
            end
        end
    endtask

    task automatic test_resets_mid_load();
        logic [255:0] ch;
        logic [31:0]  got;
        clear_mon();
        issue_req(32'h0000_1000, 4'd0);
        send_hdr(32'h0000_1000);
        for (int k = 0; k < 20; k++) send_beat(32'(k));
        bus.soc_valid = 1'b1; bus.soc_data = 32'd20; syn_rst = 1'b1;
        step();
        syn_rst = 1'b0; bus.soc_valid = 1'b0;
        n_cmp++;
        if ({bus.soc_req, bus.ul_busy, bus.ul_valid, bus.ul_err, bus.ch_update} !== 12'h000) begin
            n_bad++; $display("FAIL t6_srst_outputs: got %b %h expected 0000 00",
                              {bus.soc_req, bus.ul_busy, bus.ul_valid, bus.ul_err}, bus.ch_update);
        end
        for (int c = 0; c < 2; c++) begin
            ch = bus.ch_data[c*256 +: 256];
            n_cmp++;
            if (ch !== 256'h0) begin
                n_bad++; $display("FAIL t6_srst_ch%0d: got %h expected 0", c, ch);
            end
        end
        repeat (20) step();
        issue_req(32'h0000_1000, 4'd0);
        send_hdr(32'h0000_1000);
        for (int k = 0; k < 10; k++) send_beat(32'h55 + 32'(k));
        bus.soc_valid = 1'b1; bus.soc_data = 32'h77;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.soc_req, bus.ul_busy, bus.ul_valid, bus.ul_err, bus.ch_update} !== 12'h000) begin
            n_bad++; $display("FAIL t6_rst_outputs: got %b %h expected 0000 00",
                              {bus.soc_req, bus.ul_busy, bus.ul_valid, bus.ul_err}, bus.ch_update);
        end
        ch = bus.ch_data[255:0];
        n_cmp++;
        if (ch !== 256'h0) begin
            n_bad++; $display("FAIL t6_rst_ch0: got %h expected 0", ch);
        end
        @(negedge clk);
        bus.soc_valid = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({n_err, n_valid} !== {32'd0, 32'd0}) begin
            n_bad++; $display("FAIL t6_no_pulses: got err=%0d valid=%0d expected 0 0", n_err, n_valid);
        end
        issue_req(32'h0000_1000, 4'd1);
        send_hdr(32'h0000_1000);
        for (int k = 0; k < 8; k++) send_beat(32'h700 + 32'(k));
        n_cmp++;
        if ({bus.ul_valid, bus.ch_update} !== {1'b1, 8'h01}) begin
            n_bad++; $display("FAIL t6_reload: got valid=%b upd=%h expected 1 01", bus.ul_valid, bus.ch_update);
        end
        step();
        for (int w = 0; w < 8; w++) begin
            got = bus.ch_data[w*32 +: 32];
            n_cmp++;
            if (got !== 32'h700 + 32'(w)) begin
                n_bad++; $display("FAIL t6_reload_data w%0d: got %h expected %h", w, got, 32'h700 + 32'(w));
            end
        end
        ch = bus.ch_data[256 +: 256];
        n_cmp++;
        if (ch !== 256'h0) begin
            n_bad++; $display("FAIL t6_ch1_clear: got %h expected 0", ch);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_partial();
        test_retry_exhaust();
        test_retry_recover();
        test_timeout();
        test_resets_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
